// File: rtl/lpif_phy_ctrl_if.sv
// LPIF boundary bundle: link-layer state/beat signals plus the transmit
// req/ack handshake toward the serializer. The slave modport is the PHY
// controller; the master modport is its environment.
interface lpif_phy_ctrl_if #(
    parameter int LPIF_BUS_WIDTH = 32
) ();
    localparam int NB = LPIF_BUS_WIDTH / 8;

    logic [3:0]                lp_state_req;
    logic                      lp_force_detect;
    logic [3:0]                pl_state_sts;
    logic                      lp_irdy;
    logic [LPIF_BUS_WIDTH-1:0] lp_data;
    logic [NB-1:0]             lp_valid;
    logic [NB-1:0]             lp_tlp_start;
    logic [NB-1:0]             lp_tlp_end;
    logic [NB-1:0]             lp_dllp_start;
    logic [NB-1:0]             lp_dllp_end;
    logic                      pl_trdy;
    logic                      tx_req;
    logic                      tx_ack;
    logic [LPIF_BUS_WIDTH-1:0] tx_data;
    logic [NB-1:0]             tx_valid;
    logic [4*NB-1:0]           tx_ctrl;

    modport master (
        output lp_state_req, lp_force_detect, lp_irdy, lp_data, lp_valid,
               lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, tx_ack,
        input  pl_state_sts, pl_trdy, tx_req, tx_data, tx_valid, tx_ctrl
    );

    modport slave (
        input  lp_state_req, lp_force_detect, lp_irdy, lp_data, lp_valid,
               lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, tx_ack,
        output pl_state_sts, pl_trdy, tx_req, tx_data, tx_valid, tx_ctrl
    );
endinterface

// File: rtl/lpif_phy_ctrl.sv
// PHY-side LPIF responder: link state FSM, transmit beat FIFO and the
// req/ack hand-off to the transmit serializer.
module lpif_phy_ctrl #(
    parameter int LPIF_BUS_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 lclk,
    input  logic                 reset_n,
    lpif_phy_ctrl_if.slave       bus,
    input  logic                 ltssm_link_up,
    input  logic [2:0]           ltssm_speed,
    output logic [2:0]           pl_speed_mode,
    output logic                 ltssm_retrain_req,
    output logic                 ltssm_detect_req
);
    localparam int NB = LPIF_BUS_WIDTH / 8;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [3:0] REQ_NOP       = 4'h0;
    localparam logic [3:0] REQ_ACTIVE    = 4'h1;
    localparam logic [3:0] REQ_L1        = 4'h4;
    localparam logic [3:0] REQ_LINKRESET = 4'h9;
    localparam logic [3:0] REQ_RETRAIN   = 4'hB;

    typedef enum logic [3:0] {
        ST_RESET     = 4'h0,
        ST_ACTIVE    = 4'h1,
        ST_L1        = 4'h4,
        ST_LINKRESET = 4'h9,
        ST_RETRAIN   = 4'hB
    } state_e;

    typedef struct packed {
        logic [LPIF_BUS_WIDTH-1:0] data;
        logic [NB-1:0]             valid;
        logic [4*NB-1:0]           ctrl;
    } beat_t;

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    state_e        state_q, state_d;
    logic [2:0]    speed_q, speed_d;
    logic          retrain_q, retrain_d;
    logic          detect_q, detect_d;
    logic          l1_pend_q, l1_pend_d;
    logic          ret_seen_q, ret_seen_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    beat_t         mem_q [FIFO_DEPTH];
    beat_t         beat_in, head;
    logic          flush, push, pop;

    // Reset asserts asynchronously but releases only on an lclk edge.
    always_ff @(posedge lclk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Acceptance depends only on registered state so there is no path from
    // lp_irdy back to pl_trdy.
    assign bus.pl_trdy = (state_q == ST_ACTIVE) && (count_q < CW'(FIFO_DEPTH)) && !l1_pend_q;
    assign push        = bus.lp_irdy && bus.pl_trdy && (|bus.lp_valid);
    assign pop         = bus.tx_req && bus.tx_ack;

    assign beat_in.data  = bus.lp_data;
    assign beat_in.valid = bus.lp_valid;
    assign beat_in.ctrl  = {bus.lp_tlp_start, bus.lp_tlp_end, bus.lp_dllp_start, bus.lp_dllp_end};

    // Link state transitions, flush decision and LTSSM pulse requests.
    always_comb begin
        state_d    = state_q;
        flush      = 1'b0;
        retrain_d  = 1'b0;
        detect_d   = 1'b0;
        l1_pend_d  = 1'b0;
        ret_seen_d = (state_q == ST_RETRAIN);
        speed_d    = ltssm_link_up ? ltssm_speed : speed_q;
        if (bus.lp_force_detect) begin
            state_d  = ST_RESET;
            flush    = 1'b1;
            detect_d = 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (bus.lp_state_req == REQ_ACTIVE && ltssm_link_up) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (bus.lp_state_req == REQ_RETRAIN) begin
                        state_d   = ST_RETRAIN;
                        retrain_d = 1'b1;
                    end else if (bus.lp_state_req == REQ_LINKRESET) begin
                        state_d = ST_LINKRESET;
                        flush   = 1'b1;
                    end else if (bus.lp_state_req == REQ_L1) begin
                        // L1 waits for the transmit buffer to drain; intake is
                        // blocked meanwhile so the drain terminates.
                        if (count_q == '0 && !push) state_d = ST_L1;
                        else                        l1_pend_d = 1'b1;
                    end else if (!ltssm_link_up) begin
                        // Entry to ACTIVE required link-up, so a low level here
                        // is the falling edge.
                        state_d = ST_RESET;
                        flush   = 1'b1;
                    end
                end
                ST_RETRAIN: begin
                    if (ltssm_link_up && ret_seen_q) state_d = ST_ACTIVE;
                end
                ST_L1: begin
                    if (bus.lp_state_req == REQ_ACTIVE) begin
                        state_d   = ST_RETRAIN;
                        retrain_d = 1'b1;
                    end
                end
                ST_LINKRESET: begin
                    if (bus.lp_state_req == REQ_NOP || bus.lp_state_req == REQ_ACTIVE) begin
                        state_d  = ST_RESET;
                        detect_d = 1'b1;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end
    end

    // FIFO pointer/occupancy update; a flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control and status registers.
    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            speed_q    <= '0;
            retrain_q  <= 1'b0;
            detect_q   <= 1'b0;
            l1_pend_q  <= 1'b0;
            ret_seen_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            retrain_q  <= retrain_d;
            detect_q   <= detect_d;
            l1_pend_q  <= l1_pend_d;
            ret_seen_q <= ret_seen_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Beat storage; contents are don't-care while unoccupied.
    always_ff @(posedge lclk) begin
        if (push) mem_q[wr_ptr_q] <= beat_in;
    end

    assign head              = mem_q[rd_ptr_q];
    assign bus.tx_req        = (count_q != '0);
    assign bus.tx_data       = bus.tx_req ? head.data  : '0;
    assign bus.tx_valid      = bus.tx_req ? head.valid : '0;
    assign bus.tx_ctrl       = bus.tx_req ? head.ctrl  : '0;
    assign bus.pl_state_sts  = state_q;
    assign pl_speed_mode     = speed_q;
    assign ltssm_retrain_req = retrain_q;
    assign ltssm_detect_req  = detect_q;
endmodule

// File: tb/tb_lpif_phy_ctrl.sv
// Directed bench for lpif_phy_ctrl: bring-up, backpressure, L1 drain,
// force detect, zero-valid beat, speed capture and async reset.
module tb_lpif_phy_ctrl;
    logic       lclk;
    logic       reset_n;
    logic       ltssm_link_up;
    logic [2:0] ltssm_speed;
    logic [2:0] pl_speed_mode;
    logic       ltssm_retrain_req;
    logic       ltssm_detect_req;

    int checks   = 0;
    int failures = 0;

    lpif_phy_ctrl_if #(.LPIF_BUS_WIDTH(32)) bus ();

    lpif_phy_ctrl #(.LPIF_BUS_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .lclk              (lclk),
        .reset_n           (reset_n),
        .bus               (bus),
        .ltssm_link_up     (ltssm_link_up),
        .ltssm_speed       (ltssm_speed),
        .pl_speed_mode     (pl_speed_mode),
        .ltssm_retrain_req (ltssm_retrain_req),
        .ltssm_detect_req  (ltssm_detect_req)
    );

    initial lclk = 1'b0;
    always #5 lclk = ~lclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    task automatic push_beats(input logic [31:0] base, input int num);
        bus.lp_irdy = 1'b1;
        for (int i = 0; i < num; i++) begin
            bus.lp_data = base + 32'(i);
            chk("push_trdy", bus.pl_trdy, 1'b1);
            tick();
        end
        bus.lp_irdy = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic acc;
        reset_n              = 1'b0;
        ltssm_link_up        = 1'b0;
        ltssm_speed          = 3'd0;
        bus.lp_state_req     = 4'h0;
        bus.lp_force_detect  = 1'b0;
        bus.lp_irdy          = 1'b0;
        bus.lp_data          = 32'h0;
        bus.lp_valid         = 4'hF;
        bus.lp_tlp_start     = 4'b0001;
        bus.lp_tlp_end       = 4'b1000;
        bus.lp_dllp_start    = 4'b0000;
        bus.lp_dllp_end      = 4'b0000;
        bus.tx_ack           = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_sts",     bus.pl_state_sts, 4'h0);
        chk("rst_trdy",    bus.pl_trdy, 1'b0);
        chk("rst_txreq",   bus.tx_req, 1'b0);
        chk("rst_retrain", ltssm_retrain_req, 1'b0);
        chk("rst_detect",  ltssm_detect_req, 1'b0);
        chk("rst_speed",   pl_speed_mode, 3'd0);

        // Bring-up: link-up at cycle 5, ACTIVE visible at cycle 6
        reset_n          = 1'b1;
        bus.lp_state_req = 4'h1;
        for (int c = 1; c <= 5; c++) tick();
        chk("bu_sts_pre",  bus.pl_state_sts, 4'h0);
        chk("bu_trdy_pre", bus.pl_trdy, 1'b0);
        ltssm_link_up = 1'b1;
        tick();
        chk("bu_sts",  bus.pl_state_sts, 4'h1);
        chk("bu_trdy", bus.pl_trdy, 1'b1);

        // Backpressure: continuous irdy, no ack -> exactly 4 beats accepted
        n = 0;
        bus.lp_irdy = 1'b1;
        bus.lp_data = 32'hA0;
        for (int c = 0; c < 8; c++) begin
            acc = bus.pl_trdy;
            tick();
            if (acc) begin
                n++;
                bus.lp_data = 32'hA0 + 32'(n);
            end
        end
        bus.lp_irdy = 1'b0;
        chk("bp_accepted", 64'(n), 64'd4);
        chk("bp_trdy_full", bus.pl_trdy, 1'b0);
        chk("bp_txreq", bus.tx_req, 1'b1);
        chk("bp_ctrl", bus.tx_ctrl, 16'h1800);
        bus.tx_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_data",  bus.tx_data, 32'hA0 + 32'(i));
            chk("bp_valid", bus.tx_valid, 4'hF);
            if (i == 0) chk("bp_trdy_full_pop", bus.pl_trdy, 1'b0);
            tick();
        end
        bus.tx_ack = 1'b0;
        chk("bp_empty_req",  bus.tx_req, 1'b0);
        chk("bp_empty_data", bus.tx_data, 32'h0);

        // L1 with pending data
        push_beats(32'hB0, 2);
        bus.lp_state_req = 4'h4;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("l1_hold_sts", bus.pl_state_sts, 4'h1);
            chk("l1_hold_trdy", bus.pl_trdy, 1'b0);
        end
        bus.tx_ack = 1'b1;
        tick();
        chk("l1_pop1_sts",  bus.pl_state_sts, 4'h1);
        chk("l1_pop1_data", bus.tx_data, 32'hB1);
        tick();
        chk("l1_pop2_sts", bus.pl_state_sts, 4'h1);
        chk("l1_pop2_req", bus.tx_req, 1'b0);
        bus.tx_ack = 1'b0;
        tick();
        chk("l1_sts", bus.pl_state_sts, 4'h4);
        bus.lp_state_req = 4'h1;
        tick();
        chk("l1x_sts",     bus.pl_state_sts, 4'hB);
        chk("l1x_retrain", ltssm_retrain_req, 1'b1);
        ltssm_link_up = 1'b0;
        tick();
        chk("rt_sts",       bus.pl_state_sts, 4'hB);
        chk("rt_retrain_1", ltssm_retrain_req, 1'b0);
        chk("rt_trdy",      bus.pl_trdy, 1'b0);
        tick();
        chk("rt_sts2", bus.pl_state_sts, 4'hB);
        ltssm_link_up = 1'b1;
        tick();
        chk("rt_exit_sts", bus.pl_state_sts, 4'h1);

        // Force detect with 3 beats queued
        push_beats(32'hC0, 3);
        chk("fd_txreq_pre", bus.tx_req, 1'b1);
        bus.lp_force_detect = 1'b1;
        tick();
        bus.lp_force_detect = 1'b0;
        chk("fd_sts",    bus.pl_state_sts, 4'h0);
        chk("fd_txreq",  bus.tx_req, 1'b0);
        chk("fd_detect", ltssm_detect_req, 1'b1);
        tick();
        chk("fd_detect_1", ltssm_detect_req, 1'b0);
        chk("fd_reentry",  bus.pl_state_sts, 4'h1);
        chk("fd_txreq_1",  bus.tx_req, 1'b0);

        // Zero-valid beat is consumed and discarded
        bus.lp_valid = 4'h0;
        bus.lp_irdy  = 1'b1;
        chk("zv_trdy", bus.pl_trdy, 1'b1);
        tick();
        bus.lp_irdy  = 1'b0;
        bus.lp_valid = 4'hF;
        chk("zv_txreq", bus.tx_req, 1'b0);

        // Speed capture only while link is up; link drop also leaves ACTIVE
        ltssm_speed = 3'd4;
        tick();
        chk("sp_capture", pl_speed_mode, 3'd4);
        ltssm_link_up = 1'b0;
        ltssm_speed   = 3'd6;
        tick();
        chk("sp_hold",     pl_speed_mode, 3'd4);
        chk("ld_sts",      bus.pl_state_sts, 4'h0);
        ltssm_link_up = 1'b1;
        tick();
        chk("sp_update", pl_speed_mode, 3'd6);
        chk("ld_reentry", bus.pl_state_sts, 4'h1);

        // Async reset with a full FIFO
        push_beats(32'hD0, 4);
        chk("ar_full_trdy", bus.pl_trdy, 1'b0);
        chk("ar_full_req",  bus.tx_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_sts",    bus.pl_state_sts, 4'h0);
        chk("ar_trdy",   bus.pl_trdy, 1'b0);
        chk("ar_txreq",  bus.tx_req, 1'b0);
        chk("ar_txdata", bus.tx_data, 32'h0);
        chk("ar_speed",  pl_speed_mode, 3'd0);
        chk("ar_pulses", {ltssm_retrain_req, ltssm_detect_req}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
